// File: rtl/serializer_gearbox_pkg.sv
// Shared constants and helpers for the word-to-slice gearbox.
package serializer_pkg;
  localparam int CNT_W = 16;
  localparam logic [9:0] DEFAULT_IDLE_WORD = 10'h354;

  function automatic int ratio(input int word_w, input int slice_w);
    return word_w / slice_w;
  endfunction

  // Bit offset inside a word of the idx-th emitted slice.
  function automatic int slice_lo(input int idx, input int n_slices, input int slice_w,
                                  input bit lsb_first);
    return lsb_first ? idx * slice_w : (n_slices - 1 - idx) * slice_w;
  endfunction
endpackage

// File: rtl/serializer_gearbox_if.sv
// Word input handshake plus slice output bus of the gearbox.
interface serializer_gearbox_if #(
  parameter int CHANNELS    = 3,
  parameter int WORD_WIDTH  = 10,
  parameter int SLICE_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4
);
  import serializer_pkg::*;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [CHANNELS*WORD_WIDTH-1:0]  In_Data;
  logic                            In_Valid;
  logic                            In_Ready;
  logic                            Resync;
  logic                            Clear_Count;
  logic [CHANNELS*SLICE_WIDTH-1:0] Out_Data;
  logic                            Out_First;
  logic                            Underrun;
  logic [CNT_W-1:0]                Underrun_Count;
  logic [LW-1:0]                   Level;

  modport master (output In_Data, In_Valid, Resync, Clear_Count,
                  input  In_Ready, Out_Data, Out_First, Underrun, Underrun_Count, Level);
  modport slave  (input  In_Data, In_Valid, Resync, Clear_Count,
                  output In_Ready, Out_Data, Out_First, Underrun, Underrun_Count, Level);
endinterface

// File: rtl/serializer_gearbox_fifo.sv
// Synchronous FIFO shared by all channels; head is the oldest entry.
module gearbox_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [LW-1:0]    o_level,
  output logic             o_full,
  output logic             o_empty
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rp];
  assign o_level = r_level;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/serializer_gearbox.sv
// Multi-channel gearbox: buffers parallel words and emits one slice per channel per clock.
module serializer_gearbox
  import serializer_pkg::*;
#(
  parameter int CHANNELS    = 3,
  parameter int WORD_WIDTH  = 10,
  parameter int SLICE_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter bit LSB_FIRST   = 1'b1,
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD = WORD_WIDTH'(DEFAULT_IDLE_WORD)
) (
  input logic Clk,
  input logic Reset,
  serializer_gearbox_if.slave bus
);
  localparam int RATIO = ratio(WORD_WIDTH, SLICE_WIDTH);
  localparam int PW    = $clog2(RATIO);
  localparam int DW    = CHANNELS * WORD_WIDTH;
  localparam int SDW   = CHANNELS * SLICE_WIDTH;
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  logic [DW-1:0]  w_head, w_word, w_idle, w_order, w_idle_order;
  logic [DW-1:0]  w_shift_load, w_shift_adv;
  logic [SDW-1:0] w_first_slice, w_next_slice;
  logic [LW-1:0]  w_level;
  logic w_full, w_empty, w_load, w_pop;

  logic [DW-1:0]    r_shift;
  logic [SDW-1:0]   r_out;
  logic [PW-1:0]    r_phase;
  logic             r_first, r_und;
  logic [CNT_W-1:0] r_cnt;

  gearbox_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk), .rst(Reset),
    .i_push(bus.In_Valid), .i_wdata(bus.In_Data), .i_pop(w_pop),
    .o_head(w_head), .o_level(w_level), .o_full(w_full), .o_empty(w_empty)
  );

  assign w_idle = {CHANNELS{IDLE_WORD}};
  assign w_load = (r_phase == '0) || bus.Resync;
  assign w_pop  = w_load && !w_empty;
  assign w_word = w_empty ? w_idle : w_head;

  // Reorder each word so emission order always runs from bit 0 upward; the shifter stays LSB-only.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar k = 0; k < RATIO; k++) begin : g_sl
      assign w_order[c*WORD_WIDTH + k*SLICE_WIDTH +: SLICE_WIDTH] =
        w_word[c*WORD_WIDTH + slice_lo(k, RATIO, SLICE_WIDTH, LSB_FIRST) +: SLICE_WIDTH];
      assign w_idle_order[c*WORD_WIDTH + k*SLICE_WIDTH +: SLICE_WIDTH] =
        w_idle[c*WORD_WIDTH + slice_lo(k, RATIO, SLICE_WIDTH, LSB_FIRST) +: SLICE_WIDTH];
    end
    assign w_first_slice[c*SLICE_WIDTH +: SLICE_WIDTH] = w_order[c*WORD_WIDTH +: SLICE_WIDTH];
    assign w_next_slice[c*SLICE_WIDTH +: SLICE_WIDTH]  = r_shift[c*WORD_WIDTH +: SLICE_WIDTH];
    assign w_shift_load[c*WORD_WIDTH +: WORD_WIDTH] = w_order[c*WORD_WIDTH +: WORD_WIDTH] >> SLICE_WIDTH;
    assign w_shift_adv[c*WORD_WIDTH +: WORD_WIDTH]  = r_shift[c*WORD_WIDTH +: WORD_WIDTH] >> SLICE_WIDTH;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out   <= '0;
      r_first <= 1'b0;
      r_und   <= 1'b0;
      r_phase <= '0;
      r_shift <= w_idle_order;
    end else if (w_load) begin
      r_out   <= w_first_slice;
      r_shift <= w_shift_load;
      r_first <= 1'b1;
      r_und   <= w_empty;
      r_phase <= PW'(1);
    end else begin
      r_out   <= w_next_slice;
      r_shift <= w_shift_adv;
      r_first <= 1'b0;
      r_und   <= 1'b0;
      r_phase <= (r_phase == PW'(RATIO - 1)) ? '0 : r_phase + 1'b1;
    end
  end

  // Counts on the same edge that raises Underrun; clear wins over a coincident increment.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                  r_cnt <= '0;
    else if (bus.Clear_Count)                   r_cnt <= '0;
    else if (w_load && w_empty && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign bus.In_Ready       = !w_full;
  assign bus.Level          = w_level;
  assign bus.Out_Data       = r_out;
  assign bus.Out_First      = r_first;
  assign bus.Underrun       = r_und;
  assign bus.Underrun_Count = r_cnt;
endmodule

// File: tb/tb_serializer_gearbox.sv
// Scoreboard bench: two DUTs (LSB-first and MSB-first) share stimulus; a word-queue model predicts every cycle.
module tb_serializer_gearbox;
  import serializer_pkg::*;
  localparam int CH = 3, WW = 10, SW = 5, R = 2, D = 4;
  localparam logic [29:0] IDLE3 = {3{10'h354}};

  logic clk = 1'b0, rst = 1'b1;
  logic [29:0] in_data = '0;
  logic in_valid = 1'b0, resync = 1'b0, clr = 1'b0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  serializer_gearbox_if #(.CHANNELS(CH), .WORD_WIDTH(WW), .SLICE_WIDTH(SW), .FIFO_DEPTH(D)) bl ();
  serializer_gearbox_if #(.CHANNELS(CH), .WORD_WIDTH(WW), .SLICE_WIDTH(SW), .FIFO_DEPTH(D)) bm ();

  assign bl.In_Data = in_data;  assign bm.In_Data = in_data;
  assign bl.In_Valid = in_valid; assign bm.In_Valid = in_valid;
  assign bl.Resync = resync;    assign bm.Resync = resync;
  assign bl.Clear_Count = clr;  assign bm.Clear_Count = clr;

  serializer_gearbox #(.CHANNELS(CH), .WORD_WIDTH(WW), .SLICE_WIDTH(SW), .FIFO_DEPTH(D),
                       .LSB_FIRST(1'b1)) dut_l (.Clk(clk), .Reset(rst), .bus(bl));
  serializer_gearbox #(.CHANNELS(CH), .WORD_WIDTH(WW), .SLICE_WIDTH(SW), .FIFO_DEPTH(D),
                       .LSB_FIRST(1'b0)) dut_m (.Clk(clk), .Reset(rst), .bus(bm));

  typedef struct {
    logic [14:0] dl, dm;
    logic        first, und;
    logic [15:0] cnt;
    int          lvl;
  } exp_t;

  exp_t        exp_q[$];
  logic [29:0] mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // k-th emitted slice of each channel word, by the plain ordering rule.
  function automatic logic [14:0] slc(input logic [29:0] w, input int k, input bit lsb);
    logic [14:0] r;
    logic [9:0]  wc;
    int          idx;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      wc  = w[c*WW +: WW];
      idx = lsb ? k : R - 1 - k;
      wc  = wc >> (idx * SW);
      r[c*SW +: SW] = wc[SW-1:0];
    end
    return r;
  endfunction

  initial begin : model
    exp_t e;
    logic [29:0] m_word;
    int m_phase, m_k, m_cnt;
    bit ready, load, und;
    m_word = IDLE3; m_phase = 0; m_k = 0; m_cnt = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_phase = 0; m_k = 0; m_cnt = 0;
        e = '{15'd0, 15'd0, 1'b0, 1'b0, 16'd0, 0};
      end else begin
        ready = (mq.size() < D);
        load  = (m_phase == 0) || resync;
        und   = 1'b0;
        if (load) begin
          if (mq.size() > 0) m_word = mq.pop_front();
          else begin m_word = IDLE3; und = 1'b1; end
          m_k = 0; m_phase = 1;
        end else begin
          m_k++; m_phase = (m_phase + 1) % R;
        end
        if (in_valid && ready) mq.push_back(in_data);
        if (clr) m_cnt = 0;
        else if (und && m_cnt < 65535) m_cnt++;
        e.dl = slc(m_word, m_k, 1'b1);
        e.dm = slc(m_word, m_k, 1'b0);
        e.first = load; e.und = und; e.cnt = 16'(m_cnt); e.lvl = mq.size();
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("slice", {bl.Out_Data, bm.Out_Data, bl.Out_First, bl.Underrun, bm.Out_First, bm.Underrun},
                       {e.dl, e.dm, e.first, e.und, e.first, e.und});
        check("count", {bl.Underrun_Count, bm.Underrun_Count}, {e.cnt, e.cnt});
        check("level", {bl.Level, bm.Level, bl.In_Ready, bm.In_Ready},
                       {3'(e.lvl), 3'(e.lvl), e.lvl < D, e.lvl < D});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : driver
    int maxlvl;
    bit saw_full;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_idle_s0", {bl.Out_Data, bl.Out_First, bl.Underrun, bl.Underrun_Count},
                         {15'h5294, 1'b1, 1'b1, 16'd1});
    // Push lands on the non-load edge, so the following load edge takes it.
    in_data = {3{10'h2AB}}; in_valid = 1'b1;
    tick(1);
    check("rst_idle_s1", {bl.Out_Data, bl.Underrun}, {15'h6B5A, 1'b0});
    in_valid = 1'b0;
    tick(1);
    check("w2ab_s0", {bl.Out_Data, bl.Out_First, bl.Underrun}, {{3{5'h0B}}, 1'b1, 1'b0});
    tick(1);
    check("w2ab_s1", {bl.Out_Data, bl.Out_First}, {{3{5'h15}}, 1'b0});
    in_data = {3{10'h3E0}}; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    check("msb_s0", {bm.Out_Data, bm.Out_First}, {{3{5'h1F}}, 1'b1});
    tick(1);
    check("msb_s1", bm.Out_Data, {3{5'h00}});

    maxlvl = 0; saw_full = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 30'($urandom);
      tick(1);
      if (int'(bl.Level) > maxlvl) maxlvl = int'(bl.Level);
      if (!bl.In_Ready) saw_full = 1'b1;
    end
    in_valid = 1'b0;
    check("burst_fill", {32'(maxlvl), 31'd0, saw_full}, {32'd4, 31'd0, 1'b1});
    tick(10);

    for (int i = 0; i < 400; i++) begin
      in_data  = 30'($urandom);
      in_valid = ($urandom_range(0, 9) < 6);
      resync   = ($urandom_range(0, 7) == 0);
      clr      = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    resync = 1'b0; clr = 1'b0;

    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin in_data = 30'($urandom); tick(1); end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst", {bl.Level, bl.Out_Data, bl.Underrun_Count}, {3'd0, 15'd0, 16'd0});
    tick(2);
    rst = 1'b0;
    tick(4);

    resync = 1'b1;
    tick(65540);
    check("cnt_sat", bl.Underrun_Count, 16'hFFFF);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_prio", {bl.Underrun, bl.Underrun_Count}, {1'b1, 16'd0});
    resync = 1'b0;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
